iommu_axi_reg_adapter: RTL and testbench

- Downstream of the AXI slave connector on the IOMMU programming port.
- Consumes the axi_req_t/axi_rsp_t pair and serialises single-beat AXI reads and writes onto a simple valid/ready register bus that feeds the IOMMU register file.
- Handles one transaction at a time, arbitrates fairly between writes and reads, and returns SLVERR for bursts and oversize accesses.

---
 rtl/iommu_axi_reg_adapter.sv | 223 ++++++++++++++++++++++
 tb/tb_iommu_axi_reg_adapter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_axi_reg_adapter.sv
// AXI-to-register-bus adapter for the IOMMU programming port: serialises single-beat
// AXI reads/writes onto a valid/ready register bus, one transaction at a time.

package iommu_axi_reg_adapter_pkg;
  localparam int unsigned AXI_ADDR_WIDTH = 64;
  localparam int unsigned AXI_DATA_WIDTH = 64;
  localparam int unsigned AXI_ID_WIDTH   = 8;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic [5:0]                atop;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0]   data;
    logic [AXI_DATA_WIDTH/8-1:0] strb;
    logic                        last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
    logic                    user;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
    logic                      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module iommu_axi_reg_adapter #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned REG_ADDR_WIDTH = 12,
  parameter type axi_req_t = iommu_axi_reg_adapter_pkg::axi_req_t,
  parameter type axi_rsp_t = iommu_axi_reg_adapter_pkg::axi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  axi_req_t                  axi_req_i,
  output axi_rsp_t                  axi_rsp_o,
  output logic                      reg_req_valid_o,
  output logic                      reg_req_write_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_req_addr_o,
  output logic [DATA_WIDTH-1:0]     reg_req_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   reg_req_wstrb_o,
  input  logic                      reg_rsp_ready_i,
  input  logic [DATA_WIDTH-1:0]     reg_rsp_rdata_i,
  input  logic                      reg_rsp_error_i
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFSET     = $clog2(STRB_WIDTH);
  localparam logic [2:0]  MAX_SIZE   = 3'(OFFSET);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, W_DATA, W_DRAIN, W_REG, B_RESP, R_REG, R_RESP} state_e;

  state_e                    state_q, state_d;
  logic                      last_write_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [STRB_WIDTH-1:0]     strb_q;
  logic [1:0]                resp_q;
  logic [7:0]                cnt_q;

  logic                  grant_write, grant_read, aw_hs, ar_hs, req_err;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [2:0]            sel_size;
  logic [1:0]            sel_burst;
  logic                  unused_inputs;

  // With both channels pending, the grant flips away from whichever won last.
  assign grant_write = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_write_q);
  assign grant_read  = axi_req_i.ar_valid && !grant_write;
  assign aw_hs       = (state_q == IDLE) && grant_write;
  assign ar_hs       = (state_q == IDLE) && grant_read;

  assign sel_id    = grant_write ? axi_req_i.aw.id    : axi_req_i.ar.id;
  assign sel_addr  = grant_write ? axi_req_i.aw.addr  : axi_req_i.ar.addr;
  assign sel_len   = grant_write ? axi_req_i.aw.len   : axi_req_i.ar.len;
  assign sel_size  = grant_write ? axi_req_i.aw.size  : axi_req_i.ar.size;
  assign sel_burst = grant_write ? axi_req_i.aw.burst : axi_req_i.ar.burst;
  assign req_err   = (sel_len != 8'd0) || (sel_size > MAX_SIZE) || (sel_burst == 2'b11);

  assign unused_inputs = ^{axi_req_i, sel_addr};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    state_d         = state_q;
    axi_rsp_o       = '0;
    reg_req_valid_o = 1'b0;
    reg_req_write_o = 1'b0;
    reg_req_addr_o  = addr_q;
    reg_req_wdata_o = '0;
    reg_req_wstrb_o = '0;
    case (state_q)
      IDLE: begin
        axi_rsp_o.aw_ready = rst_ni && grant_write;
        axi_rsp_o.ar_ready = rst_ni && grant_read;
        if (aw_hs)      state_d = req_err ? W_DRAIN : W_DATA;
        else if (ar_hs) state_d = req_err ? R_RESP : R_REG;
      end
      W_DATA: begin
        axi_rsp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) state_d = W_REG;
      end
      W_DRAIN: begin
        axi_rsp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid && cnt_q == 8'd0) state_d = B_RESP;
      end
      W_REG: begin
        reg_req_valid_o = 1'b1;
        reg_req_write_o = 1'b1;
        reg_req_wdata_o = data_q;
        reg_req_wstrb_o = strb_q;
        if (reg_rsp_ready_i) state_d = B_RESP;
      end
      B_RESP: begin
        axi_rsp_o.b_valid = 1'b1;
        axi_rsp_o.b.id    = id_q;
        axi_rsp_o.b.resp  = resp_q;
        if (axi_req_i.b_ready) state_d = IDLE;
      end
      R_REG: begin
        reg_req_valid_o = 1'b1;
        if (reg_rsp_ready_i) state_d = R_RESP;
      end
      R_RESP: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.id    = id_q;
        axi_rsp_o.r.data  = data_q;
        axi_rsp_o.r.resp  = resp_q;
        axi_rsp_o.r.last  = (cnt_q == 8'd0);
        if (axi_req_i.r_ready && cnt_q == 8'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_write_q <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      strb_q       <= '0;
      resp_q       <= RESP_OKAY;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
      case (state_q)
        IDLE: if (aw_hs || ar_hs) begin
          id_q         <= sel_id;
          addr_q       <= {sel_addr[REG_ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
          cnt_q        <= sel_len;
          resp_q       <= req_err ? RESP_SLVERR : RESP_OKAY;
          last_write_q <= aw_hs;
          data_q       <= '0;
        end
        W_DATA: if (axi_req_i.w_valid) begin
          data_q <= axi_req_i.w.data;
          strb_q <= axi_req_i.w.strb;
        end
        W_DRAIN: if (axi_req_i.w_valid && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        W_REG: if (reg_rsp_ready_i) resp_q <= reg_rsp_error_i ? RESP_SLVERR : RESP_OKAY;
        R_REG: if (reg_rsp_ready_i) begin
          resp_q <= reg_rsp_error_i ? RESP_SLVERR : RESP_OKAY;
          data_q <= reg_rsp_rdata_i;
          cnt_q  <= '0;
        end
        R_RESP: if (axi_req_i.r_ready && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iommu_axi_reg_adapter.sv
// Directed bench for iommu_axi_reg_adapter: queues of expected register requests and
// B/R responses are filled as stimulus is driven and drained by a negedge monitor.

module tb_iommu_axi_reg_adapter;
  import iommu_axi_reg_adapter_pkg::*;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  axi_req_t    axi_req;
  axi_rsp_t    axi_rsp;
  logic        reg_req_valid, reg_req_write, reg_rsp_ready, reg_rsp_error;
  logic [11:0] reg_req_addr;
  logic [63:0] reg_req_wdata, reg_rsp_rdata;
  logic [7:0]  reg_req_wstrb;

  iommu_axi_reg_adapter dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .axi_req_i       (axi_req),
    .axi_rsp_o       (axi_rsp),
    .reg_req_valid_o (reg_req_valid),
    .reg_req_write_o (reg_req_write),
    .reg_req_addr_o  (reg_req_addr),
    .reg_req_wdata_o (reg_req_wdata),
    .reg_req_wstrb_o (reg_req_wstrb),
    .reg_rsp_ready_i (reg_rsp_ready),
    .reg_rsp_rdata_i (reg_rsp_rdata),
    .reg_rsp_error_i (reg_rsp_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register file model: stalls reg_delay cycles, then completes with an address-tagged value.
  int unsigned reg_delay = 0;
  int unsigned wait_cnt  = 0;
  logic        reg_err   = 1'b0;
  assign reg_rsp_ready = reg_req_valid && (wait_cnt >= reg_delay);
  assign reg_rsp_error = reg_err;
  assign reg_rsp_rdata = 64'hA5A5_0000_0000_0000 | {52'h0, reg_req_addr};
  always @(posedge clk) wait_cnt <= (reg_req_valid && !reg_rsp_ready) ? wait_cnt + 1 : 0;

  function automatic logic [63:0] model_rdata(input logic [11:0] a);
    return 64'hA5A5_0000_0000_0000 | {52'h0, a};
  endfunction

  typedef struct { logic write; logic [11:0] addr; logic [63:0] wdata; logic [7:0] wstrb; } reg_exp_t;
  typedef struct { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;

  reg_exp_t reg_q[$];
  b_exp_t   b_q[$];
  r_exp_t   r_q[$];
  logic     grant_log[$];

  int cyc = 0;
  int aw_cyc, ar_cyc, w_cyc, reg_first_cyc, reg_cyc, b_cyc, r_first_cyc;
  logic prev_reg_valid = 1'b0, prev_r_valid = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_ni) begin
      check("aw_ar_ready_exclusive", 64'(axi_rsp.aw_ready & axi_rsp.ar_ready), 64'd0);
      if (axi_rsp.b_valid || axi_rsp.r_valid)
        check("no_accept_while_busy", 64'({axi_rsp.aw_ready, axi_rsp.ar_ready}), 64'd0);
      if (axi_req.aw_valid && axi_rsp.aw_ready) begin grant_log.push_back(1'b1); aw_cyc <= cyc; end
      if (axi_req.ar_valid && axi_rsp.ar_ready) begin grant_log.push_back(1'b0); ar_cyc <= cyc; end
      if (axi_req.w_valid && axi_rsp.w_ready) w_cyc <= cyc;
      if (reg_req_valid) begin
        if (!prev_reg_valid) reg_first_cyc <= cyc;
        if (reg_q.size() == 0) check("reg_unexpected", 64'(reg_q.size()), 64'd1);
        else begin
          check("reg_write", 64'(reg_req_write), 64'(reg_q[0].write));
          check("reg_addr", 64'(reg_req_addr), 64'(reg_q[0].addr));
          check("reg_wstrb", 64'(reg_req_wstrb), 64'(reg_q[0].wstrb));
          if (reg_q[0].write) check("reg_wdata", reg_req_wdata, reg_q[0].wdata);
          if (reg_rsp_ready) begin void'(reg_q.pop_front()); reg_cyc <= cyc; end
        end
      end
      if (axi_rsp.b_valid) begin
        if (b_q.size() == 0) check("b_unexpected", 64'(b_q.size()), 64'd1);
        else begin
          check("b_id", 64'(axi_rsp.b.id), 64'(b_q[0].id));
          check("b_resp", 64'(axi_rsp.b.resp), 64'(b_q[0].resp));
          if (axi_req.b_ready) begin void'(b_q.pop_front()); b_cyc <= cyc; end
        end
      end
      if (axi_rsp.r_valid) begin
        if (!prev_r_valid) r_first_cyc <= cyc;
        if (r_q.size() == 0) check("r_unexpected", 64'(r_q.size()), 64'd1);
        else begin
          check("r_id", 64'(axi_rsp.r.id), 64'(r_q[0].id));
          check("r_data", axi_rsp.r.data, r_q[0].data);
          check("r_resp", 64'(axi_rsp.r.resp), 64'(r_q[0].resp));
          check("r_last", 64'(axi_rsp.r.last), 64'(r_q[0].last));
          if (axi_req.r_ready) void'(r_q.pop_front());
        end
      end
    end
    prev_reg_valid <= reg_req_valid;
    prev_r_valid   <= axi_rsp.r_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    axi_req.aw.id = id; axi_req.aw.addr = addr; axi_req.aw.len = len;
    axi_req.aw.size = size; axi_req.aw.burst = burst; axi_req.aw_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin @(negedge clk); if (axi_rsp.aw_ready) break; end
    check("aw_accept", 64'(axi_rsp.aw_ready), 64'd1);
    @(posedge clk); #1 axi_req.aw_valid = 1'b0;
  endtask

  task automatic drive_ar(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    axi_req.ar.id = id; axi_req.ar.addr = addr; axi_req.ar.len = len;
    axi_req.ar.size = size; axi_req.ar.burst = burst; axi_req.ar_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin @(negedge clk); if (axi_rsp.ar_ready) break; end
    check("ar_accept", 64'(axi_rsp.ar_ready), 64'd1);
    @(posedge clk); #1 axi_req.ar_valid = 1'b0;
  endtask

  task automatic drive_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    axi_req.w.data = data; axi_req.w.strb = strb; axi_req.w.last = last; axi_req.w_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin @(negedge clk); if (axi_rsp.w_ready) break; end
    check("w_accept", 64'(axi_rsp.w_ready), 64'd1);
    @(posedge clk); #1 axi_req.w_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 300 && (reg_q.size() + b_q.size() + r_q.size()) != 0; n++) step(1);
    check(tag, 64'(reg_q.size() + b_q.size() + r_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rsp"}, 64'(axi_rsp === '0), 64'd1);
    check({tag, "_reg_valid"}, 64'(reg_req_valid), 64'd0);
    check({tag, "_reg_write"}, 64'(reg_req_write), 64'd0);
    check({tag, "_reg_fields"}, 64'({reg_req_addr, reg_req_wstrb} | 20'(reg_req_wdata != 0)), 64'd0);
  endtask

  initial begin
    axi_req = '0;
    rst_ni  = 1'b0;
    #1 check_outputs_zero("reset");
    step(2);
    rst_ni = 1'b1;
    axi_req.b_ready = 1'b1;
    axi_req.r_ready = 1'b1;
    step(1);

    // Single 64-bit write with zero-wait register file.
    reg_q.push_back('{1'b1, 12'h010, 64'hDEADBEEF_CAFEF00D, 8'hFF});
    b_q.push_back('{8'd3, OKAY});
    fork
      drive_aw(8'd3, 64'h1010, 8'd0, 3'd3, 2'b01);
      drive_w(64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1);
    join
    drain("write_drain");
    check("write_w_latency", 64'(w_cyc - aw_cyc), 64'd1);
    check("write_reg_latency", 64'(reg_cyc - aw_cyc), 64'd2);
    check("write_b_latency", 64'(b_cyc - aw_cyc), 64'd3);

    // Plain read latency.
    reg_q.push_back('{1'b0, 12'h020, 64'h0, 8'h00});
    r_q.push_back('{8'd7, model_rdata(12'h020), OKAY, 1'b1});
    drive_ar(8'd7, 64'h2020, 8'd0, 3'd3, 2'b01);
    drain("read_drain");
    check("read_reg_latency", 64'(reg_cyc - ar_cyc), 64'd1);
    check("read_r_latency", 64'(r_first_cyc - ar_cyc), 64'd2);

    // Read with register error after a 4-cycle stall.
    reg_delay = 4; reg_err = 1'b1;
    reg_q.push_back('{1'b0, 12'h018, 64'h0, 8'h00});
    r_q.push_back('{8'd5, model_rdata(12'h018), SLVERR, 1'b1});
    drive_ar(8'd5, 64'h018, 8'd0, 3'd3, 2'b01);
    drain("read_err_drain");
    check("read_err_stall", 64'(reg_cyc - reg_first_cyc), 64'd4);
    check("read_err_r_after_ready", 64'(r_first_cyc - reg_cyc), 64'd1);

    // Unaligned 4-byte write, register error: address aligned down, SLVERR on B.
    reg_delay = 0;
    reg_q.push_back('{1'b1, 12'h230, 64'h11223344_55667788, 8'h0F});
    b_q.push_back('{8'd12, SLVERR});
    fork
      drive_aw(8'd12, 64'h1237, 8'd0, 3'd2, 2'b01);
      drive_w(64'h11223344_55667788, 8'h0F, 1'b1);
    join
    drain("write_err_drain");
    reg_err = 1'b0;

    // Rejected read burst: four SLVERR beats, zero data, last on the fourth only.
    for (int i = 0; i < 4; i++) r_q.push_back('{8'd9, 64'h0, SLVERR, (i == 3)});
    drive_ar(8'd9, 64'h100, 8'd3, 3'd3, 2'b01);
    drain("read_burst_drain");

    // Oversize read and reserved-burst write.
    r_q.push_back('{8'd13, 64'h0, SLVERR, 1'b1});
    drive_ar(8'd13, 64'h108, 8'd0, 3'd4, 2'b01);
    drain("read_oversize_drain");
    b_q.push_back('{8'd14, SLVERR});
    fork
      drive_aw(8'd14, 64'h110, 8'd0, 3'd3, 2'b11);
      drive_w(64'h1, 8'hFF, 1'b1);
    join
    drain("write_burst3_drain");

    // Rejected write burst of two beats: both sunk, single SLVERR.
    b_q.push_back('{8'd4, SLVERR});
    fork
      drive_aw(8'd4, 64'h200, 8'd1, 3'd3, 2'b01);
      begin
        drive_w(64'hAAAA, 8'hFF, 1'b0);
        drive_w(64'hBBBB, 8'hFF, 1'b1);
      end
    join
    drain("write_burst_drain");

    // Fair arbitration from reset with both channels always requesting.
    rst_ni = 1'b0; step(1); rst_ni = 1'b1; step(1);
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      reg_q.push_back('{1'b1, 12'h300, 64'h0123_4567_89AB_CDEF, 8'hFF});
      reg_q.push_back('{1'b0, 12'h308, 64'h0, 8'h00});
      b_q.push_back('{8'd1, OKAY});
      r_q.push_back('{8'd2, model_rdata(12'h308), OKAY, 1'b1});
    end
    axi_req.aw.id = 8'd1; axi_req.aw.addr = 64'h300; axi_req.aw.len = 8'd0;
    axi_req.aw.size = 3'd3; axi_req.aw.burst = 2'b01;
    axi_req.ar.id = 8'd2; axi_req.ar.addr = 64'h308; axi_req.ar.len = 8'd0;
    axi_req.ar.size = 3'd3; axi_req.ar.burst = 2'b01;
    axi_req.w.data = 64'h0123_4567_89AB_CDEF; axi_req.w.strb = 8'hFF; axi_req.w.last = 1'b1;
    axi_req.aw_valid = 1'b1; axi_req.ar_valid = 1'b1; axi_req.w_valid = 1'b1;
    for (int n = 0; n < 200 && grant_log.size() < 4; n++) step(1);
    axi_req.aw_valid = 1'b0; axi_req.ar_valid = 1'b0; axi_req.w_valid = 1'b0;
    drain("arb_drain");
    check("arb_grant_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("arb_grant_%0d", i), 64'(grant_log[i]), 64'((i % 2) == 0));

    // Backpressure on B then R, with a read waiting behind the stalled B.
    axi_req.b_ready = 1'b0; axi_req.r_ready = 1'b0;
    reg_q.push_back('{1'b1, 12'h040, 64'h5555_6666_7777_8888, 8'hF0});
    b_q.push_back('{8'd6, OKAY});
    reg_q.push_back('{1'b0, 12'h048, 64'h0, 8'h00});
    r_q.push_back('{8'd8, model_rdata(12'h048), OKAY, 1'b1});
    fork
      drive_aw(8'd6, 64'h040, 8'd0, 3'd3, 2'b01);
      drive_w(64'h5555_6666_7777_8888, 8'hF0, 1'b1);
    join
    fork
      drive_ar(8'd8, 64'h048, 8'd0, 3'd3, 2'b01);
      begin
        for (int n = 0; n < 50 && !axi_rsp.b_valid; n++) step(1);
        step(5);
        check("b_held", 64'(axi_rsp.b_valid), 64'd1);
        axi_req.b_ready = 1'b1;
      end
    join
    for (int n = 0; n < 50 && !axi_rsp.r_valid; n++) step(1);
    step(5);
    check("r_held", 64'(axi_rsp.r_valid), 64'd1);
    axi_req.r_ready = 1'b1;
    drain("backpressure_drain");

    // Reset while the register write is pending; nothing stale afterwards.
    reg_delay = 1000;
    reg_q.push_back('{1'b1, 12'h050, 64'hFEED_FACE_0000_1111, 8'hFF});
    b_q.push_back('{8'd10, OKAY});
    fork
      drive_aw(8'd10, 64'h050, 8'd0, 3'd3, 2'b01);
      drive_w(64'hFEED_FACE_0000_1111, 8'hFF, 1'b1);
    join
    for (int n = 0; n < 50 && !reg_req_valid; n++) step(1);
    check("midop_in_w_reg", 64'(reg_req_valid), 64'd1);
    #2 rst_ni = 1'b0;
    #1 check_outputs_zero("midop_reset");
    reg_q.delete(); b_q.delete();
    step(2);
    rst_ni = 1'b1;
    reg_delay = 0;
    step(1);
    reg_q.push_back('{1'b1, 12'h058, 64'h0F0F_0F0F_0F0F_0F0F, 8'h3C});
    b_q.push_back('{8'd11, OKAY});
    fork
      drive_aw(8'd11, 64'h058, 8'd0, 3'd3, 2'b01);
      drive_w(64'h0F0F_0F0F_0F0F_0F0F, 8'h3C, 1'b1);
    join
    drain("post_reset_drain");
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
